v_list_engine: RTL and testbench
================================

Name: v_list_engine

Overview:
- Parametrised successor to the per-context sorted list `v`.
- Holds CONTEXT_N independent sorted lists of up to ENTRIES_N (key, size) entries, with widths configurable via KEY_W/SIZE_W/ID_W.
- Sort direction is selectable via ORDER_DESC.
- Adds a REPLACE command, full-list eviction, per-update error reporting and a registered lookup-valid.
- Sits behind the update/lookup buses and drives the level-0 notify bus to downstream consumers.

Parameters:
- CONTEXT_N, 128, number of independent lists.
- ENTRIES_N, 4, max entries per list (>=2).
- KEY_W, 16, key width.
- SIZE_W, 16, size width.
- ID_W, $clog2(CONTEXT_N), context id width.
- ORDER_DESC, 0, 0 = level 0 holds smallest key; 1 = level 0 holds largest key.
- Derived: LVL_W=$clog2(ENTRIES_N); LS_W=$clog2(ENTRIES_N+1).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- i_upd_vld  in  1  update request.
- i_upd_prod_id  in  ID_W  target context.
- i_upd_cmd  in  2  0=CLEAR, 1=ADD, 2=DELETE, 3=REPLACE.
- i_upd_key  in  KEY_W  key.
- i_upd_size  in  SIZE_W  size (ignored for CLEAR/DELETE).
- o_upd_done  out  1  update completed pulse.
- o_upd_err  out  2  with done: 0=OK, 1=DUP, 2=FULL, 3=MISS.
- o_upd_evict  out  1  with done: ADD displaced the tail entry.
- i_lut_vld  in  1  lookup request.
- i_lut_prod_id  in  ID_W  context.
- i_lut_level  in  LVL_W  level.
- o_lut_vld  out  1  lookup response valid.
- o_lut_key  out  KEY_W  key at level.
- o_lut_size  out  SIZE_W  size at level.
- o_lut_error  out  1  level >= listsize.
- o_lut_listsize  out  LS_W  entries in context.
- o_lv0_vld  out  1  level-0 changed pulse.
- o_lv0_prod_id  out  ID_W  context.
- o_lv0_key  out  KEY_W  new level-0 key.
- o_lv0_size  out  SIZE_W  new level-0 size.
- o_lv0_empty  out  1  list became empty (key/size = 0).

Behaviour:
- One update accepted per cycle; no backpressure.
- Update pipeline:
  - Request sampled at edge N is registered into a stage.
  - The new list for that context is computed combinationally and written at edge N+1.
  - o_upd_done/err/evict and the notify outputs are registered at N+1 (1-cycle latency).
  - Back-to-back updates to the same context need no forwarding (stage reads post-write state).
- Lists are kept sorted and compact; keys are unique within a context.
- Commands:
  - CLEAR: listsize=0; err OK.
  - ADD, key present: unchanged, DUP.
  - ADD, not full: insert at sorted position, shift lower-ranked entries down.
  - ADD, full, key ranks ahead of tail: insert, drop tail, OK, evict=1.
  - ADD, full, key does not rank ahead of tail: unchanged, FULL.
  - DELETE: remove entry, shift up; absent key gives MISS.
  - REPLACE: overwrite size of existing key, order unchanged; absent key gives MISS.
- Notify: o_lv0_vld=1 at N+1 when the level-0 (key,size) differs from its pre-update value, or the list went non-empty to empty (o_lv0_empty=1). CLEAR of an empty list produces no notify.
- Lookup:
  - Sampled at edge M, reads array state just before M.
  - Outputs registered at M, with o_lut_vld=1 for one cycle.
  - An update written at N+1 is visible to lookups sampled at N+2 or later.
  - When error=1, key and size are 0; listsize is always valid.
- Reset: all listsizes 0; all outputs 0. An update in the stage at reset assertion is dropped, with no done or notify.

Optional Feature:
- Macro V_LIST_STATS_EN.
- With it defined: adds outputs o_stat_ok, o_stat_err and o_stat_evict, each 32 bits. Each counts completed updates (OK, any non-OK, evict respectively), saturates at all-ones and is cleared by rst.
- Without it: ports and counters are absent; the core is unchanged.

Test Plan (ENTRIES_N=4, ORDER_DESC=0):
- ADD keys 30,10,20 to ctx 5 on consecutive cycles -> done err=0 each; notify key 30, then 10, none for 20; lookup levels 0..2 = 10,20,30, listsize=3.
- ctx 5 = {10,20,30,40}: ADD 5 -> evict=1, list {5,10,20,30}, notify key 5; ADD 50 -> err=FULL, list unchanged, no notify.
- ADD 20 again -> DUP; DELETE 99 -> MISS; REPLACE 20 size 7 -> OK, no notify; REPLACE 5 size 9 -> notify key 5 size 9.
- DELETE all keys of ctx 5 -> final delete gives o_lv0_empty=1; lookup level 0 -> error=1, key=0, listsize=0.
- Lookup sampled at edge N+1 of an ADD returns the old state; at N+2 returns the new state. Updates to ctx 5 and ctx 6 interleave without cross-talk.
- Assert rst with an update in the stage -> no done/notify; all lookups listsize=0.

Source files
------------

// File: rtl/v_list_engine.sv
// v_list_engine: per-context sorted (key,size) lists with update/lookup/level-0 notify; V_LIST_STATS_EN adds completion counters
module v_list_engine #(
    parameter int CONTEXT_N = 128,
    parameter int ENTRIES_N = 4,
    parameter int KEY_W = 16,
    parameter int SIZE_W = 16,
    parameter int ID_W = $clog2(CONTEXT_N),
    parameter bit ORDER_DESC = 1'b0,
    localparam int LVL_W = $clog2(ENTRIES_N),
    localparam int LS_W = $clog2(ENTRIES_N + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_upd_vld,
    input  logic [ID_W-1:0]   i_upd_prod_id,
    input  logic [1:0]        i_upd_cmd,
    input  logic [KEY_W-1:0]  i_upd_key,
    input  logic [SIZE_W-1:0] i_upd_size,
    output logic              o_upd_done,
    output logic [1:0]        o_upd_err,
    output logic              o_upd_evict,
    input  logic              i_lut_vld,
    input  logic [ID_W-1:0]   i_lut_prod_id,
    input  logic [LVL_W-1:0]  i_lut_level,
    output logic              o_lut_vld,
    output logic [KEY_W-1:0]  o_lut_key,
    output logic [SIZE_W-1:0] o_lut_size,
    output logic              o_lut_error,
    output logic [LS_W-1:0]   o_lut_listsize,
    output logic              o_lv0_vld,
    output logic [ID_W-1:0]   o_lv0_prod_id,
    output logic [KEY_W-1:0]  o_lv0_key,
    output logic [SIZE_W-1:0] o_lv0_size,
    output logic              o_lv0_empty
`ifdef V_LIST_STATS_EN
    ,
    output logic [31:0]       o_stat_ok,
    output logic [31:0]       o_stat_err,
    output logic [31:0]       o_stat_evict
`endif
);
    localparam logic [1:0] CMD_CLEAR = 2'd0, CMD_ADD = 2'd1, CMD_DELETE = 2'd2;
    localparam logic [1:0] ERR_OK = 2'd0, ERR_DUP = 2'd1, ERR_FULL = 2'd2, ERR_MISS = 2'd3;
    logic [KEY_W-1:0]  key_q  [CONTEXT_N][ENTRIES_N];
    logic [SIZE_W-1:0] size_q [CONTEXT_N][ENTRIES_N];
    logic [LS_W-1:0]   len_q  [CONTEXT_N];
    logic              stg_vld_q;
    logic [ID_W-1:0]   stg_id_q;
    logic [1:0]        stg_cmd_q;
    logic [KEY_W-1:0]  stg_key_q;
    logic [SIZE_W-1:0] stg_size_q;
    logic [KEY_W-1:0]  cur_key [ENTRIES_N];
    logic [SIZE_W-1:0] cur_size [ENTRIES_N];
    logic [LS_W-1:0]   cur_len;
    logic [KEY_W-1:0]  key_d [ENTRIES_N];
    logic [SIZE_W-1:0] size_d [ENTRIES_N];
    logic [LS_W-1:0]   len_d;
    logic [LS_W-1:0]   pos, hidx;
    logic              hit, full, evict_d, lv0_chg;
    logic [1:0]        err_d;
    always_comb begin
        cur_key = key_q[stg_id_q];
        cur_size = size_q[stg_id_q];
        cur_len = len_q[stg_id_q];
        hit = 1'b0;
        hidx = '0;
        pos = '0;
        for (int e = 0; e < ENTRIES_N; e++) begin
            if (LS_W'(e) < cur_len) begin
                if (cur_key[e] == stg_key_q) begin
                    hit = 1'b1;
                    hidx = LS_W'(e);
                end
                if (ORDER_DESC ? (cur_key[e] > stg_key_q) : (cur_key[e] < stg_key_q)) pos = pos + 1'b1;
            end
        end
        full = cur_len == LS_W'(ENTRIES_N);
        key_d = cur_key;
        size_d = cur_size;
        len_d = cur_len;
        err_d = ERR_OK;
        evict_d = 1'b0;
        case (stg_cmd_q)
            CMD_CLEAR: len_d = '0;
            CMD_ADD: begin
                if (hit) err_d = ERR_DUP;
                else if (full && pos == LS_W'(ENTRIES_N)) err_d = ERR_FULL;
                else begin
                    for (int e = 0; e < ENTRIES_N; e++) begin
                        key_d[e] = (LS_W'(e) == pos) ? stg_key_q : cur_key[e];
                        size_d[e] = (LS_W'(e) == pos) ? stg_size_q : cur_size[e];
                    end
                    for (int e = 1; e < ENTRIES_N; e++) begin
                        if (LS_W'(e) > pos) begin
                            key_d[e] = cur_key[e-1];
                            size_d[e] = cur_size[e-1];
                        end
                    end
                    len_d = full ? cur_len : cur_len + 1'b1;
                    evict_d = full;
                end
            end
            CMD_DELETE: begin
                if (!hit) err_d = ERR_MISS;
                else begin
                    for (int e = 0; e < ENTRIES_N - 1; e++) begin
                        if (LS_W'(e) >= hidx) begin
                            key_d[e] = cur_key[e+1];
                            size_d[e] = cur_size[e+1];
                        end
                    end
                    len_d = cur_len - 1'b1;
                end
            end
            default: begin
                if (!hit) err_d = ERR_MISS;
                else for (int e = 0; e < ENTRIES_N; e++) if (LS_W'(e) == hidx) size_d[e] = stg_size_q;
            end
        endcase
        lv0_chg = (len_d != '0) ? (cur_len == '0 || key_d[0] != cur_key[0] || size_d[0] != cur_size[0]) : (cur_len != '0);
    end
    // An update still in the stage when rst is sampled is discarded, never written.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < CONTEXT_N; c++) len_q[c] <= '0;
        end else if (stg_vld_q) begin
            len_q[stg_id_q] <= len_d;
            key_q[stg_id_q] <= key_d;
            size_q[stg_id_q] <= size_d;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            stg_vld_q <= 1'b0;
            stg_id_q <= '0;
            stg_cmd_q <= '0;
            stg_key_q <= '0;
            stg_size_q <= '0;
            o_upd_done <= 1'b0;
            o_upd_err <= '0;
            o_upd_evict <= 1'b0;
            o_lv0_vld <= 1'b0;
            o_lv0_prod_id <= '0;
            o_lv0_key <= '0;
            o_lv0_size <= '0;
            o_lv0_empty <= 1'b0;
        end else begin
            stg_vld_q <= i_upd_vld;
            stg_id_q <= i_upd_prod_id;
            stg_cmd_q <= i_upd_cmd;
            stg_key_q <= i_upd_key;
            stg_size_q <= i_upd_size;
            o_upd_done <= stg_vld_q;
            o_upd_err <= stg_vld_q ? err_d : '0;
            o_upd_evict <= stg_vld_q & evict_d;
            o_lv0_vld <= stg_vld_q & lv0_chg;
            o_lv0_prod_id <= (stg_vld_q && lv0_chg) ? stg_id_q : '0;
            o_lv0_key <= (stg_vld_q && lv0_chg && len_d != '0) ? key_d[0] : '0;
            o_lv0_size <= (stg_vld_q && lv0_chg && len_d != '0) ? size_d[0] : '0;
            o_lv0_empty <= stg_vld_q & lv0_chg & (len_d == '0);
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            o_lut_vld <= 1'b0;
            o_lut_key <= '0;
            o_lut_size <= '0;
            o_lut_error <= 1'b0;
            o_lut_listsize <= '0;
        end else begin
            o_lut_vld <= i_lut_vld;
            o_lut_error <= LS_W'(i_lut_level) >= len_q[i_lut_prod_id];
            o_lut_key <= (LS_W'(i_lut_level) >= len_q[i_lut_prod_id]) ? '0 : key_q[i_lut_prod_id][i_lut_level];
            o_lut_size <= (LS_W'(i_lut_level) >= len_q[i_lut_prod_id]) ? '0 : size_q[i_lut_prod_id][i_lut_level];
            o_lut_listsize <= len_q[i_lut_prod_id];
        end
    end
`ifdef V_LIST_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            o_stat_ok <= '0;
            o_stat_err <= '0;
            o_stat_evict <= '0;
        end else if (stg_vld_q) begin
            if (err_d == ERR_OK && o_stat_ok != '1) o_stat_ok <= o_stat_ok + 1'b1;
            if (err_d != ERR_OK && o_stat_err != '1) o_stat_err <= o_stat_err + 1'b1;
            if (evict_d && o_stat_evict != '1) o_stat_evict <= o_stat_evict + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_v_list_engine.sv
// tb_v_list_engine: directed table-driven checks of v_list_engine with ENTRIES_N=4, ascending order
module tb_v_list_engine;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_upd_vld = 1'b0;
    logic [6:0]  i_upd_prod_id = '0;
    logic [1:0]  i_upd_cmd = '0;
    logic [15:0] i_upd_key = '0;
    logic [15:0] i_upd_size = '0;
    logic        o_upd_done;
    logic [1:0]  o_upd_err;
    logic        o_upd_evict;
    logic        i_lut_vld = 1'b0;
    logic [6:0]  i_lut_prod_id = '0;
    logic [1:0]  i_lut_level = '0;
    logic        o_lut_vld;
    logic [15:0] o_lut_key;
    logic [15:0] o_lut_size;
    logic        o_lut_error;
    logic [2:0]  o_lut_listsize;
    logic        o_lv0_vld;
    logic [6:0]  o_lv0_prod_id;
    logic [15:0] o_lv0_key;
    logic [15:0] o_lv0_size;
    logic        o_lv0_empty;
    int n_asrt = 0;
    int n_fail = 0;
    typedef struct packed {
        bit          lut;
        logic [6:0]  id;
        logic [1:0]  cmd;
        logic [15:0] key;
        logic [15:0] size;
        logic [1:0]  lvl;
        logic [1:0]  err;
        bit          evict;
        bit          nv;
        logic [15:0] ek;
        logic [15:0] es;
        bit          empty;
        logic [2:0]  ls;
    } vec_t;
    vec_t tbl[$];
    vec_t bq[$];
    v_list_engine dut (
        .clk(clk), .rst(rst),
        .i_upd_vld(i_upd_vld), .i_upd_prod_id(i_upd_prod_id), .i_upd_cmd(i_upd_cmd),
        .i_upd_key(i_upd_key), .i_upd_size(i_upd_size),
        .o_upd_done(o_upd_done), .o_upd_err(o_upd_err), .o_upd_evict(o_upd_evict),
        .i_lut_vld(i_lut_vld), .i_lut_prod_id(i_lut_prod_id), .i_lut_level(i_lut_level),
        .o_lut_vld(o_lut_vld), .o_lut_key(o_lut_key), .o_lut_size(o_lut_size),
        .o_lut_error(o_lut_error), .o_lut_listsize(o_lut_listsize),
        .o_lv0_vld(o_lv0_vld), .o_lv0_prod_id(o_lv0_prod_id), .o_lv0_key(o_lv0_key),
        .o_lv0_size(o_lv0_size), .o_lv0_empty(o_lv0_empty)
    );
    always #5 clk = ~clk;
    function automatic vec_t U(int id, int cmd, int key, int size, int err, bit ev, bit nv, int ek, int es, bit em);
        vec_t v = '0;
        v.id = 7'(id); v.cmd = 2'(cmd); v.key = 16'(key); v.size = 16'(size);
        v.err = 2'(err); v.evict = ev; v.nv = nv; v.ek = 16'(ek); v.es = 16'(es); v.empty = em;
        return v;
    endfunction
    function automatic vec_t L(int id, int lvl, int ek, int es, bit le, int ls);
        vec_t v = '0;
        v.lut = 1'b1; v.id = 7'(id); v.lvl = 2'(lvl); v.ek = 16'(ek); v.es = 16'(es); v.empty = le; v.ls = 3'(ls);
        return v;
    endfunction
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_asrt++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask
    task automatic chk_upd(input string tag, input vec_t v);
        chk({tag, " done"}, 32'(o_upd_done), 1);
        chk({tag, " err"}, 32'(o_upd_err), 32'(v.err));
        chk({tag, " evict"}, 32'(o_upd_evict), 32'(v.evict));
        chk({tag, " lv0_vld"}, 32'(o_lv0_vld), 32'(v.nv));
        if (v.nv) begin
            chk({tag, " lv0_id"}, 32'(o_lv0_prod_id), 32'(v.id));
            chk({tag, " lv0_key"}, 32'(o_lv0_key), 32'(v.ek));
            chk({tag, " lv0_size"}, 32'(o_lv0_size), 32'(v.es));
            chk({tag, " lv0_empty"}, 32'(o_lv0_empty), 32'(v.empty));
        end
    endtask
    task automatic chk_lut(input string tag, input vec_t v);
        chk({tag, " lut_vld"}, 32'(o_lut_vld), 1);
        chk({tag, " lut_key"}, 32'(o_lut_key), 32'(v.ek));
        chk({tag, " lut_size"}, 32'(o_lut_size), 32'(v.es));
        chk({tag, " lut_err"}, 32'(o_lut_error), 32'(v.empty));
        chk({tag, " lut_ls"}, 32'(o_lut_listsize), 32'(v.ls));
    endtask
    task automatic drive(input vec_t v);
        i_upd_vld = !v.lut; i_upd_prod_id = v.id; i_upd_cmd = v.cmd; i_upd_key = v.key; i_upd_size = v.size;
        i_lut_vld = v.lut; i_lut_prod_id = v.id; i_lut_level = v.lvl;
    endtask
    task automatic idle();
        i_upd_vld = 1'b0;
        i_lut_vld = 1'b0;
    endtask
    task automatic apply(input string tag, input vec_t v);
        @(negedge clk);
        drive(v);
        @(posedge clk);
        #1 idle();
        if (v.lut) chk_lut(tag, v);
        else begin
            @(posedge clk);
            #1 chk_upd(tag, v);
        end
    endtask
    task automatic burst(input string tag);
        for (int i = 0; i <= bq.size(); i++) begin
            @(negedge clk);
            if (i < bq.size()) drive(bq[i]);
            else idle();
            @(posedge clk);
            #1;
            if (i > 0) chk_upd($sformatf("%s%0d", tag, i - 1), bq[i-1]);
        end
        bq.delete();
    endtask
    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst done", 32'(o_upd_done), 0);
        chk("rst lv0_vld", 32'(o_lv0_vld), 0);
        chk("rst lut_vld", 32'(o_lut_vld), 0);
        apply("rst lut", L(5, 0, 0, 0, 1, 0));
        bq.push_back(U(5, 1, 30, 300, 0, 0, 1, 30, 300, 0));
        bq.push_back(U(5, 1, 10, 100, 0, 0, 1, 10, 100, 0));
        bq.push_back(U(5, 1, 20, 200, 0, 0, 0, 0, 0, 0));
        burst("b2b");
        tbl.push_back(L(5, 0, 10, 100, 0, 3));
        tbl.push_back(L(5, 1, 20, 200, 0, 3));
        tbl.push_back(L(5, 2, 30, 300, 0, 3));
        tbl.push_back(L(5, 3, 0, 0, 1, 3));
        tbl.push_back(U(5, 1, 40, 400, 0, 0, 0, 0, 0, 0));
        tbl.push_back(U(5, 1, 5, 50, 0, 1, 1, 5, 50, 0));
        tbl.push_back(L(5, 3, 30, 300, 0, 4));
        tbl.push_back(U(5, 1, 50, 1, 2, 0, 0, 0, 0, 0));
        tbl.push_back(L(5, 3, 30, 300, 0, 4));
        tbl.push_back(U(5, 1, 20, 9, 1, 0, 0, 0, 0, 0));
        tbl.push_back(U(5, 2, 99, 0, 3, 0, 0, 0, 0, 0));
        tbl.push_back(U(5, 3, 20, 7, 0, 0, 0, 0, 0, 0));
        tbl.push_back(L(5, 2, 20, 7, 0, 4));
        tbl.push_back(U(5, 3, 5, 9, 0, 0, 1, 5, 9, 0));
        tbl.push_back(U(5, 3, 77, 1, 3, 0, 0, 0, 0, 0));
        tbl.push_back(U(5, 2, 5, 0, 0, 0, 1, 10, 100, 0));
        tbl.push_back(L(5, 0, 10, 100, 0, 3));
        tbl.push_back(U(5, 2, 20, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(U(5, 2, 10, 0, 0, 0, 1, 30, 300, 0));
        tbl.push_back(U(5, 2, 30, 0, 0, 0, 1, 0, 0, 1));
        tbl.push_back(L(5, 0, 0, 0, 1, 0));
        tbl.push_back(U(5, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(U(6, 1, 7, 70, 0, 0, 1, 7, 70, 0));
        tbl.push_back(U(6, 0, 0, 0, 0, 0, 1, 0, 0, 1));
        for (int i = 0; i < tbl.size(); i++) apply($sformatf("t%0d", i), tbl[i]);
        @(negedge clk);
        drive(U(5, 1, 60, 600, 0, 0, 0, 0, 0, 0));
        @(posedge clk);
        @(negedge clk);
        idle();
        drive(L(5, 0, 0, 0, 0, 0));
        @(posedge clk);
        #1;
        chk("vis N+1 done", 32'(o_upd_done), 1);
        chk_lut("vis N+1", L(5, 0, 0, 0, 1, 0));
        @(negedge clk);
        @(posedge clk);
        #1 idle();
        chk_lut("vis N+2", L(5, 0, 60, 600, 0, 1));
        bq.push_back(U(6, 1, 3, 33, 0, 0, 1, 3, 33, 0));
        bq.push_back(U(5, 1, 70, 700, 0, 0, 0, 0, 0, 0));
        bq.push_back(U(6, 1, 1, 11, 0, 0, 1, 1, 11, 0));
        bq.push_back(U(5, 1, 65, 650, 0, 0, 0, 0, 0, 0));
        burst("ilv");
        tbl.delete();
        tbl.push_back(L(5, 0, 60, 600, 0, 3));
        tbl.push_back(L(5, 1, 65, 650, 0, 3));
        tbl.push_back(L(5, 2, 70, 700, 0, 3));
        tbl.push_back(L(6, 0, 1, 11, 0, 2));
        tbl.push_back(L(6, 1, 3, 33, 0, 2));
        for (int i = 0; i < tbl.size(); i++) apply($sformatf("il%0d", i), tbl[i]);
        @(negedge clk);
        drive(U(7, 1, 5, 55, 0, 0, 0, 0, 0, 0));
        @(posedge clk);
        @(negedge clk);
        idle();
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rstmid done", 32'(o_upd_done), 0);
        chk("rstmid lv0_vld", 32'(o_lv0_vld), 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("rstmid done2", 32'(o_upd_done), 0);
        chk("rstmid lv0_vld2", 32'(o_lv0_vld), 0);
        apply("rstmid c5", L(5, 0, 0, 0, 1, 0));
        apply("rstmid c6", L(6, 0, 0, 0, 1, 0));
        apply("rstmid c7", L(7, 0, 0, 0, 1, 0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end
endmodule
